// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite widths, types and response codes.
// Used by the memory responder and its bus interface.
package axi_lite_pkg;

    localparam int ADDR_WIDTH  = 12;
    localparam int DATA_WIDTH  = 8;
    localparam int STRB_WIDTH  = 1;
    localparam int BUFFER_SIZE = 4096;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [STRB_WIDTH-1:0] strb_t;
    typedef logic [1:0]            resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_mem_slave_if.sv
// AXI4-Lite channel bundle between an initiator and the
// memory responder.
interface axi_lite_mem_slave_if;
    import axi_lite_pkg::*;

    addr_t awaddr;
    logic  awvalid;
    logic  awready;
    data_t wdata;
    strb_t wstrb;
    logic  wvalid;
    logic  wready;
    resp_t bresp;
    logic  bvalid;
    logic  bready;
    addr_t araddr;
    logic  arvalid;
    logic  arready;
    data_t rdata;
    resp_t rresp;
    logic  rvalid;
    logic  rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid,
        output bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid,
        input  bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi_lite_byte_ram.sv
// Byte RAM: one synchronous write port, one registered read port.
// Same-address read and write on one edge returns the old byte.
module axi_lite_byte_ram
    import axi_lite_pkg::*;
#(
    parameter int DEPTH = BUFFER_SIZE,
    parameter int IW    = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  data_t         wdata,
    input  logic          re,
    input  logic [IW-1:0] raddr,
    output data_t         rdata
);

    data_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite responder over a byte RAM: independent AW/W capture,
// single outstanding B and R, one-cycle read latency.
module axi_lite_mem_slave
    import axi_lite_pkg::*;
#(
    parameter int MEM_DEPTH = BUFFER_SIZE
) (
    input logic aclk,
    input logic aresetn,
    axi_lite_mem_slave_if.slave bus
);

    localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic  aw_full, w_full;
    addr_t aw_addr_q;
    data_t w_data_q;
    strb_t w_strb_q;
    logic  bvalid_q, rvalid_q;
    resp_t bresp_q, rresp_q;
    data_t ram_q;

    logic  aw_hs, w_hs, ar_hs, write_go;
    addr_t wr_addr;
    data_t wr_data;
    strb_t wr_strb;
    logic  wr_mapped, ar_mapped;

    // Readies come from registers only.
    assign bus.awready = !aw_full && !bvalid_q;
    assign bus.wready  = !w_full && !bvalid_q;
    assign bus.arready = !rvalid_q;

    assign aw_hs = bus.awvalid && bus.awready;
    assign w_hs  = bus.wvalid && bus.wready;
    assign ar_hs = bus.arvalid && bus.arready;

    assign wr_addr = aw_full ? aw_addr_q : bus.awaddr;
    assign wr_data = w_full ? w_data_q : bus.wdata;
    assign wr_strb = w_full ? w_strb_q : bus.wstrb;

    assign write_go = (aw_full || aw_hs) && (w_full || w_hs)
                      && !bvalid_q;

    assign wr_mapped = 32'(wr_addr) < 32'(MEM_DEPTH);
    assign ar_mapped = 32'(bus.araddr) < 32'(MEM_DEPTH);

    assign bus.bvalid = bvalid_q;
    assign bus.bresp  = bresp_q;
    assign bus.rvalid = rvalid_q;
    assign bus.rresp  = rresp_q;
    assign bus.rdata  = (rresp_q == RESP_SLVERR) ? '0 : ram_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else if (write_go) begin
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
        end else begin
            if (aw_hs) begin
                aw_full   <= 1'b1;
                aw_addr_q <= bus.awaddr;
            end
            if (w_hs) begin
                w_full   <= 1'b1;
                w_data_q <= bus.wdata;
                w_strb_q <= bus.wstrb;
            end
            if (bvalid_q && bus.bready) bvalid_q <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rresp_q  <= ar_mapped ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_q && bus.rready) begin
            rvalid_q <= 1'b0;
        end
    end

    axi_lite_byte_ram #(
        .DEPTH (MEM_DEPTH),
        .IW    (IW)
    ) u_ram (
        .clk   (aclk),
        .rst_n (aresetn),
        .we    (write_go && wr_mapped && wr_strb[0] && aresetn),
        .waddr (wr_addr[IW-1:0]),
        .wdata (wr_data),
        .re    (ar_hs && ar_mapped),
        .raddr (bus.araddr[IW-1:0]),
        .rdata (ram_q)
    );

endmodule

// File: doc/axi_lite_mem_slave.md
# axi_lite_mem_slave

AXI4-Lite responder (slave end) backed by a byte-wide memory of `BUFFER_SIZE` locations, answering the initiator-side traffic produced by the verification environment. It sits as the DUT-side endpoint on the shared `axi_lite_bus_t` channels, accepting write address and data independently, committing writes and issuing B responses. It also serves reads through AR/R with one-cycle latency.

## Interface
- `MEM_DEPTH`, default `BUFFER_SIZE` (4096): number of implemented byte locations; addresses `>= MEM_DEPTH` are unmapped.
- `aclk`  in  1  single clock; all state changes on rising edge.
- `aresetn`  in  1  asynchronous, active-low reset.
- `awaddr`  in  `ADDR_WIDTH` (12)  write address; `awvalid` in 1; `awready` out 1.
- `wdata`  in  `DATA_WIDTH` (8)  write data; `wstrb` in `STRB_WIDTH` (1); `wvalid` in 1; `wready` out 1.
- `bresp`  out  2  write response; `bvalid` out 1; `bready` in 1.
- `araddr`  in  `ADDR_WIDTH`  read address; `arvalid` in 1; `arready` out 1.
- `rdata`  out  `DATA_WIDTH`  read data; `rresp` out 2; `rvalid` out 1; `rready` in 1.

## Operation
- Handshake on a channel = `valid && ready` at a rising edge.
- Write path holds one AW slot (`aw_full`, captured address) and one W slot (`w_full`, captured data/strobe).
- `awready = !aw_full && !bvalid`; `wready = !w_full && !bvalid`.
- `write_go = (aw_full || aw_hs) && (w_full || w_hs) && !bvalid`. Use captured values, else incoming ones.
- On `write_go`: if address `< MEM_DEPTH` and `wstrb[0]`, write the byte; `bresp = RESP_OKAY`. If address `< MEM_DEPTH` and strobe 0, no write; `bresp = RESP_OKAY`. If address unmapped, no write; `bresp = RESP_SLVERR`. Clear both slots; set `bvalid`.
- AW may precede W or follow it by any number of cycles; either order yields one write.
- `bvalid` holds, with `bresp` stable, until `bready`; cleared on the B handshake edge.
- Read path: `arready = !rvalid`. On AR handshake, register `rdata = mem[araddr]` with `rresp = RESP_OKAY` (mapped), or `rdata = 0` with `rresp = RESP_SLVERR` (unmapped). Set `rvalid`.
- `rvalid`, `rdata` and `rresp` hold until `rready`; cleared on the R handshake edge. A new AR is accepted the cycle after.
- Read and write paths are independent. If an AR handshake and `write_go` fall on the same edge for the same address, the read returns the old byte (read-before-write).
- RESP_EXOKAY and RESP_DECERR are never issued.

## Timing
- Reset values: `awready = wready = arready = 1`; `bvalid = rvalid = 0`; `bresp = rresp = 00`; `rdata = 0`; both slots empty. Memory contents are not reset and are retained across reset.
- Reset asserted mid-transaction discards captured AW/W and any pending B/R. No memory write occurs on the reset edge.
- Write latency: `bvalid` is high in the cycle after the edge on which the later of AW/W handshakes.
- Read latency: `rvalid` is high in the cycle after the AR handshake edge.
- Throughput with `bready`/`rready` tied high: one write every 2 cycles and one read every 2 cycles. `ready` drops while the response is pending.
- Readies depend only on registers, with no combinational path from any input valid to any ready.

## Structure
- `axi_lite_pkg` supplies `ADDR_WIDTH`, `DATA_WIDTH`, `STRB_WIDTH`, `BUFFER_SIZE`, `addr_t`/`data_t`/`strb_t`/`resp_t` and the `RESP_*` constants. No new package items are needed.
- One natural sub-module: `axi_lite_byte_ram`, a synchronous single-write / single-read byte RAM of `MEM_DEPTH` entries with a registered read. Handshake logic stays in the top module.

## Test plan
- Write 0xA5 to 0x004 (AW and W same cycle, `bready` = 1) -> `bvalid` next cycle, `bresp` = 00. Read 0x004 -> `rdata` = 0xA5, `rresp` = 00.
- W (0x3C) three cycles before AW (0x014) -> `wready` low after W, one write; read 0x014 returns 0x3C.
- Write with `wstrb` = 0 to 0x004 holding 0xA5 -> `bresp` = 00; read still returns 0xA5.
- `MEM_DEPTH` = 16, write/read 0x020 -> `bresp` = 10, `rresp` = 10, `rdata` = 0; no location changed.
- `bready` and `rready` held low 5 cycles -> `bvalid`/`rvalid` and payload stable; `awready`/`wready`/`arready` low throughout.
- Reset pulsed while AW captured but W pending -> after release all readies = 1, no B issued. Later full write/read to the same address works normally.
